// File: rtl/mini_mips_pkg.sv
// Shared MIPS definitions: ALU control codes used by the ALU controller, ALU and MDU,
// plus the MDU state encoding.
package mini_mips_pkg;

   localparam logic [3:0] ALU_MULT  = 4'b1100;
   localparam logic [3:0] ALU_MULTU = 4'b1101;
   localparam logic [3:0] ALU_DIV   = 4'b1110;
   localparam logic [3:0] ALU_DIVU  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   // All four MDU codes share the 11xx prefix.
   function automatic logic is_mdu_code(input logic [3:0] code);
      return code[3:2] == 2'b11;
   endfunction

endpackage

// File: rtl/mini_mips_mdu_signfix.sv
// Sign handling around the unsigned MDU core: absolute values at entry and
// conditional two's-complement negation of the raw result at FIX.
module mini_mips_mdu_signfix #(
   parameter int WIDTH = 32
) (
   input  logic             sgn_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] abs_a_o,
   output logic [WIDTH-1:0] abs_b_o,
   input  logic             mul_i,
   input  logic             neg_lo_i,
   input  logic             neg_hi_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic [WIDTH-1:0] fix_hi_o,
   output logic [WIDTH-1:0] fix_lo_o
);

   logic [2*WIDTH-1:0] prod;

   assign abs_a_o = (sgn_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
   assign abs_b_o = (sgn_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;
   assign prod    = {hi_i, lo_i};

   // A product is negated as one 2*WIDTH value; quotient and remainder independently.
   always_comb begin
      if (mul_i) begin
         {fix_hi_o, fix_lo_o} = neg_lo_i ? ('0 - prod) : prod;
      end else begin
         fix_lo_o = neg_lo_i ? ('0 - lo_i) : lo_i;
         fix_hi_o = neg_hi_i ? ('0 - hi_i) : hi_i;
      end
   end

endmodule

// File: rtl/mini_mips_mdu.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide,
// WIDTH iterations, owning the architectural HI/LO registers.
module mini_mips_mdu
   import mini_mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, hi_q, lo_q;
   logic             div_q, dz_q, neg_lo_q, neg_hi_q, done_q;
   logic             accept, calc, fix, sgn, div_ok;
   logic [WIDTH-1:0] abs_a, abs_b, fix_hi, fix_lo, step_hi, step_lo;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;

   assign accept = start && is_mdu_code(alu_control) && (state_q == S_IDLE);
   assign sgn    = ~alu_control[0];
   assign done   = done_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

   mini_mips_mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
      .sgn_i    (sgn),
      .a_i      (op_a),
      .b_i      (op_b),
      .abs_a_o  (abs_a),
      .abs_b_o  (abs_b),
      .mul_i    (~div_q),
      .neg_lo_i (neg_lo_q),
      .neg_hi_i (neg_hi_q),
      .hi_i     (acc_hi_q),
      .lo_i     (acc_lo_q),
      .fix_hi_o (fix_hi),
      .fix_lo_o (fix_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      calc = (state_q == S_CALC);
      fix  = (state_q == S_FIX);
   end

   // acc_lo holds multiplier (mult) or dividend/quotient (div); opnd holds the other operand.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd_q};
      div_ok   = ~div_diff[WIDTH];
      if (div_q) begin
         step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         div_q    <= 1'b0;
         dz_q     <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= fix;
         if (accept) begin
            div_q    <= alu_control[1];
            dz_q     <= alu_control[1] && (op_b == '0);
            acc_hi_q <= '0;
            acc_lo_q <= alu_control[1] ? abs_a : abs_b;
            opnd_q   <= alu_control[1] ? abs_b : abs_a;
            neg_lo_q <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_hi_q <= sgn & op_a[WIDTH-1];
            cnt_q    <= CW'(WIDTH - 1);
         end else if (calc) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - CW'(1);
         end
         // Divide by zero keeps the hi = dividend from the core but forces lo to all ones.
         if (fix) begin
            hi_q <= fix_hi;
            lo_q <= dz_q ? '1 : fix_lo;
         end else if ((state_q == S_IDLE) && !accept) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mini_mips_mdu.sv
// Directed + random bench for mini_mips_mdu with a result scoreboard.
module tb_mini_mips_mdu;
   import mini_mips_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, hi_we, lo_we, busy, done;
   logic [3:0]   alu_control;
   logic [W-1:0] op_a, op_b, wdata, hi, lo;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t sb_q[$];

   always #5 clk = ~clk;

   mini_mips_mdu #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic res_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t            r;
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      sa = a;
      sb = b;
      r  = '0;
      case (c)
         ALU_MULT: begin
            sp = longint'(sa) * longint'(sb);
            {r.hi, r.lo} = sp;
         end
         ALU_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {r.hi, r.lo} = up;
         end
         ALU_DIV: begin
            if (b == '0) begin
               r.hi = a; r.lo = '1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.hi = '0; r.lo = 32'h8000_0000;
            end else begin
               r.lo = sa / sb; r.hi = sa % sb;
            end
         end
         default: begin
            if (b == '0) begin
               r.hi = a; r.lo = '1;
            end else begin
               r.lo = a / b; r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Issues one op, checks busy/hold/latency each cycle, returns in the done cycle.
   task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int start_at, input int we_at, input logic we_on_start);
      logic [W-1:0] prev_hi, prev_lo;
      res_t         got;
      int           n;
      sb_q.push_back(model(code, a, b));
      prev_hi     = hi;
      prev_lo     = lo;
      alu_control = code;
      op_a        = a;
      op_b        = b;
      start       = 1'b1;
      lo_we       = we_on_start;
      wdata       = 32'hDEAD_BEEF;
      step();
      start = 1'b0;
      lo_we = 1'b0;
      n     = 0;
      while (!done && n < 60) begin
         chk("busy_calc", W'(busy), 1);
         chk("hi_hold", hi, prev_hi);
         chk("lo_hold", lo, prev_lo);
         if (n == start_at) begin
            start = 1'b1; alu_control = ALU_MULTU; op_a = ~a; op_b = 32'd3;
         end
         if (n == we_at) begin
            hi_we = 1'b1; wdata = 32'h5555_AAAA;
         end
         step();
         start = 1'b0;
         hi_we = 1'b0;
         n++;
      end
      chk("latency", W'(n), W'(W + 1));
      chk("busy_done", W'(busy), 0);
      chk("sb_depth", W'(sb_q.size()), 1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk("hi_result", hi, got.hi);
         chk("lo_result", lo, got.lo);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   codes [4];
      logic [W-1:0] ra, rb;
      codes = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
      rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      alu_control = 4'b0; op_a = '0; op_b = '0; wdata = '0;
      step(); step();
      chk("rst_busy", W'(busy), 0);
      chk("rst_done", W'(done), 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      rst = 1'b0;
      step();

      hi_we = 1'b1; wdata = 32'h1111_2222;
      step();
      hi_we = 1'b0;
      chk("mthi", hi, 32'h1111_2222);
      chk("mthi_no_done", W'(done), 0);

      run_op(ALU_MULT, 32'hFFFF_FFFF, 32'd2, -1, -1, 1'b0);
      step();
      chk("done_one_cycle", W'(done), 0);
      run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, -1, -1, 1'b0);
      step();
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
      // back-to-back: next start lands in the done cycle
      run_op(ALU_DIVU, 32'd7, 32'd2, -1, -1, 1'b0);
      run_op(ALU_DIV, 32'h1234_5678, 32'd0, -1, -1, 1'b0);
      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
      step();
      // second start at edge 10 and mthi at edge 5 are both dropped
      run_op(ALU_MULT, 32'h0001_2345, 32'hFFFF_FF00, 9, 4, 1'b0);
      step();
      // mtlo on the same edge as an accepted start loses
      run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd10, -1, -1, 1'b1);
      step();
      run_op(ALU_DIVU, 32'd5, 32'd0, -1, -1, 1'b0);
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd0, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom();
         rb = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 50)) ^ {32{ra[0]}};
         run_op(codes[i % 4], ra, rb, -1, -1, 1'b0);
         step();
      end

      alu_control = 4'b0010; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      chk("illegal_busy", W'(busy), 0);
      step();
      chk("illegal_busy2", W'(busy), 0);
      chk("illegal_done", W'(done), 0);

      alu_control = ALU_MULT; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      chk("pre_rst_busy", W'(busy), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", W'(busy), 0);
      chk("async_rst_done", W'(done), 0);
      chk("async_rst_hi", hi, 0);
      chk("async_rst_lo", lo, 0);
      #2;
      rst = 1'b0;
      lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
      step();
      lo_we = 1'b0;
      chk("mtlo_after_rst", lo, 32'hA5A5_A5A5);
      chk("hi_after_rst", hi, 0);
      repeat (40) step();
      chk("aborted_no_done", W'(done), 0);
      chk("aborted_lo", lo, 32'hA5A5_A5A5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
